ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction-fetch stage of the MIPS core, directly upstream of the control decoder. Holds the PC, fetches each word from instruction memory over a req/ack handshake, latches it in an instruction register, and presents opcode/funct to the decoder and the full word to the datapath. When the datapath retires the instruction, the unit computes the next PC from the decoder's Jump/Branch/Jr outputs and starts the next fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held until ack.
- imem_addr  out  32  fetch address (= pc).
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  latched instruction register.
- opcode  out  6  instr[31:26], to decoder.
- funct  out  6  instr[5:0], to decoder.
- instr_valid  out  1  instr is current and executable (EXEC state).
- pc  out  32  address of current instruction.
- pc_plus4  out  32  pc+4, used by JAL link write.
- exec_done  in  1  datapath retires current instruction; next-PC inputs valid.
- jump  in  1  decoder Jump.
- branch  in  1  decoder Branch.
- branch_cond  in  1  datapath branch condition met (BEQ equal / BNE not-equal).
- jr  in  1  decoder Jr.
- jr_target  in  32  rs register value.
- fetch_err  out  1  sticky misaligned-target flag.

## Operation
- States: FETCH, EXEC, ERROR.
- Reset: pc=RESET_PC, instr=0, state=FETCH, fetch_err=0, instr_valid=0, imem_req=0 while rst_n low.
- FETCH: imem_req=1, imem_addr=pc stable. On imem_ack: instr<=imem_rdata, go EXEC. No ack → stay, request held, address unchanged.
- EXEC: instr_valid=1, imem_req=0. Stay until exec_done. On exec_done: pc<=next_pc, go FETCH (or ERROR).
- next_pc priority: jr → jr_target; else jump → {pc_plus4[31:28], instr[25:0], 2'b00}; else branch & branch_cond → pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4.
- Arithmetic: 32-bit, modulo 2^32; pc_plus4 wraps 32'hFFFF_FFFC → 0. Branch offset sign-extended to 32 bits before shift.
- Misalignment: if next_pc[1:0] != 0 on exec_done, pc is not updated, state → ERROR, fetch_err=1. ERROR: imem_req=0, instr_valid=0; exits only via reset.
- jump/branch/jr/exec_done ignored outside EXEC; imem_ack ignored outside FETCH.
- branch without branch_cond falls through to pc_plus4.

## Timing
- pc, instr, state, fetch_err registered on clk rising edge; reset asynchronous on rst_n falling edge, synchronous release.
- opcode, funct, pc_plus4, imem_addr, imem_req, instr_valid combinational from registers only (no input-to-output paths).
- Ack in cycle N → instr_valid high in N+1. exec_done in EXEC cycle M → imem_req high in M+1 with new address.
- Minimum throughput: 2 cycles/instruction (ack immediate, exec_done in first EXEC cycle).
- Reset mid-FETCH: request dropped immediately; outstanding ack after release of reset is ignored until the new FETCH issues (memory must not ack stale requests).
- Reset mid-EXEC: instruction abandoned, no PC update.

## Test plan
- Reset, RESET_PC=0x400000, ack on first req with 0x20080005 → imem_addr=0x400000, next cycle instr_valid=1, opcode=0x08, pc_plus4=0x400004; exec_done → next imem_addr=0x400004.
- BEQ at 0x100, instr[15:0]=0xFFFE, branch=1, branch_cond=1 → next fetch 0x0FC; same with branch_cond=0 → 0x104.
- J at 0x00400010 with instr[25:0]=0x0100008 → next fetch 0x00400020; jr=1 and jump=1 together, jr_target=0x80 → 0x80 (jr wins).
- Ack delayed 5 cycles → imem_req and imem_addr stable all 5 cycles, instr_valid low until cycle after ack; exec_done pulsed during FETCH ignored.
- jr_target=0x102 → fetch_err=1, state ERROR, imem_req stays 0, pc unchanged; rst_n pulse → fetch_err=0, fetch restarts at RESET_PC.
- pc=0xFFFFFFFC, sequential instruction retires → next fetch address 0x00000000.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: instruction-memory req/ack fetch bus
interface ifetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  modport master (output req, output addr, input ack, input rdata);
  modport slave (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: MIPS fetch stage holding PC and instruction register, computing next PC on retire
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ifetch_unit_if.master        imem,
  output logic [31:0]          instr,
  output logic [5:0]           opcode,
  output logic [5:0]           funct,
  output logic                 instr_valid,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  input  logic                 exec_done,
  input  logic                 jump,
  input  logic                 branch,
  input  logic                 branch_cond,
  input  logic                 jr,
  input  logic [31:0]          jr_target,
  output logic                 fetch_err
);
  typedef enum logic [1:0] {FETCH, EXEC, ERROR} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, next_pc;
  logic        err_q, err_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    next_pc  = jr ? jr_target
             : jump ? {pc_plus4[31:28], instr_q[25:0], 2'b00}
             : (branch && branch_cond) ? pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00}
             : pc_plus4;
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    err_d    = err_q;
    if (state_q == FETCH && imem.ack) begin
      instr_d = imem.rdata;
      state_d = EXEC;
    end
    if (state_q == EXEC && exec_done) begin
      state_d = (next_pc[1:0] != 2'b00) ? ERROR : FETCH;
      err_d   = err_q | (next_pc[1:0] != 2'b00);
      pc_d    = (next_pc[1:0] != 2'b00) ? pc_q : next_pc;
    end
  end
  assign imem.req    = rst_n && state_q == FETCH;
  assign imem.addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign instr_valid = state_q == EXEC;
  assign pc          = pc_q;
  assign fetch_err   = err_q;
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: randomized and directed check of ifetch_unit against a behavioural model
module tb_ifetch_unit;
  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam int MF = 0, ME = 1, MX = 2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr, pc, pc_plus4, jr_target;
  logic [5:0]  opcode, funct;
  logic        instr_valid, exec_done, jump, branch, branch_cond, jr, fetch_err;
  int          n_cmp = 0, n_bad = 0;
  int          m_mode = MF;
  logic [31:0] m_pc = RPC, m_instr = 32'h0;
  logic        m_err = 1'b0;
  ifetch_unit_if bus();
  ifetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .imem(bus.master),
    .instr(instr), .opcode(opcode), .funct(funct), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .exec_done(exec_done), .jump(jump),
    .branch(branch), .branch_cond(branch_cond), .jr(jr), .jr_target(jr_target),
    .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] m_next(logic [31:0] p, logic [31:0] w, logic r, logic [31:0] t,
                                         logic j, logic b, logic c);
    logic [31:0] p4;
    int          off;
    p4  = p + 32'd4;
    off = int'($signed(w[15:0]));
    if (r) return t;
    if (j) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (b && c) return p4 + 32'(off * 4);
    return p4;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    logic [31:0] np;
    if (!rst_n) begin
      m_mode = MF; m_pc = RPC; m_instr = 32'h0; m_err = 1'b0;
    end else if (m_mode == MF) begin
      if (bus.ack) begin m_instr = bus.rdata; m_mode = ME; end
    end else if (m_mode == ME && exec_done) begin
      np = m_next(m_pc, m_instr, jr, jr_target, jump, branch, branch_cond);
      if (np % 4 != 0) begin m_mode = MX; m_err = 1'b1; end
      else begin m_pc = np; m_mode = MF; end
    end
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req", 32'(bus.req), 0);
      chk("rst_valid", 32'(instr_valid), 0);
      chk("rst_err", 32'(fetch_err), 0);
      chk("rst_pc", pc, RPC);
      chk("rst_instr", instr, 0);
    end else begin
      chk("req", 32'(bus.req), 32'(m_mode == MF));
      chk("valid", 32'(instr_valid), 32'(m_mode == ME));
      chk("addr", bus.addr, m_pc);
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("instr", instr, m_instr);
      chk("opcode", 32'(opcode), m_instr >> 26);
      chk("funct", 32'(funct), m_instr % 64);
      chk("err", 32'(fetch_err), 32'(m_err));
    end
  end
  task automatic cyc();
    @(negedge clk);
    #2;
  endtask
  task automatic fetch(logic [31:0] w);
    for (int i = 0; i < 20 && !bus.req; i++) cyc();
    chk("req_wait", 32'(bus.req), 1);
    bus.ack = 1'b1; bus.rdata = w;
    cyc();
    bus.ack = 1'b0;
  endtask
  task automatic retire(logic r, logic [31:0] t, logic j, logic b, logic c);
    jr = r; jr_target = t; jump = j; branch = b; branch_cond = c; exec_done = 1'b1;
    cyc();
    {jr, jump, branch, branch_cond, exec_done} = 5'b0;
    jr_target = 32'h0;
  endtask
  initial begin
    bus.ack = 1'b0; bus.rdata = 32'h0; jr_target = 32'h0;
    {jr, jump, branch, branch_cond, exec_done} = 5'b0;
    #1 rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("first_req", 32'(bus.req), 1);
    chk("first_addr", bus.addr, 32'h0040_0000);
    bus.ack = 1'b1; bus.rdata = 32'h2008_0005;
    cyc();
    bus.ack = 1'b0;
    chk("first_valid", 32'(instr_valid), 1);
    chk("first_opcode", 32'(opcode), 32'h08);
    chk("first_pc4", pc_plus4, 32'h0040_0004);
    exec_done = 1'b1;
    cyc();
    exec_done = 1'b0;
    chk("seq_addr", bus.addr, 32'h0040_0004);
    fetch(32'h0); retire(1, 32'h100, 0, 0, 0);
    fetch(32'h1000_FFFE); retire(0, 0, 0, 1, 1);
    chk("beq_taken", bus.addr, 32'h0000_00FC);
    fetch(32'h0); retire(1, 32'h100, 0, 0, 0);
    fetch(32'h1000_FFFE); retire(0, 0, 0, 1, 0);
    chk("beq_not_taken", bus.addr, 32'h0000_0104);
    fetch(32'h0); retire(1, 32'h0040_0010, 0, 0, 0);
    fetch(32'h0810_0008); retire(0, 0, 1, 0, 0);
    chk("j_target", bus.addr, 32'h0040_0020);
    fetch(32'h0810_0008); retire(1, 32'h80, 1, 0, 0);
    chk("jr_wins", bus.addr, 32'h0000_0080);
    for (int i = 0; i < 5; i++) begin
      chk("wait_req", 32'(bus.req), 1);
      chk("wait_addr", bus.addr, 32'h80);
      chk("wait_valid", 32'(instr_valid), 0);
      exec_done = (i == 2);
      cyc();
    end
    exec_done = 1'b0;
    chk("late_pc", pc, 32'h80);
    fetch(32'h0);
    chk("late_valid", 32'(instr_valid), 1);
    retire(1, 32'hFFFF_FFFC, 0, 0, 0);
    fetch(32'h0);
    chk("wrap_pc4", pc_plus4, 32'h0);
    retire(0, 0, 0, 0, 0);
    chk("wrap_addr", bus.addr, 32'h0);
    fetch(32'h0); retire(1, 32'h102, 0, 0, 0);
    chk("mis_err", 32'(fetch_err), 1);
    chk("mis_req", 32'(bus.req), 0);
    chk("mis_pc", pc, 32'h0);
    cyc(); cyc();
    chk("err_hold_req", 32'(bus.req), 0);
    chk("err_hold_valid", 32'(instr_valid), 0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rec_err", 32'(fetch_err), 0);
    chk("rec_addr", bus.addr, RPC);
    for (int k = 0; k < 4000; k++) begin
      logic [31:0] jt;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, fetch_err ? 4 : 250) == 0) rst_n = 1'b0;
      bus.ack     = bus.req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
      bus.rdata   = $urandom;
      exec_done   = $urandom_range(0, 2) == 0;
      jump        = $urandom_range(0, 3) == 0;
      branch      = $urandom_range(0, 2) == 0;
      branch_cond = $urandom_range(0, 1) == 1;
      jr          = $urandom_range(0, 5) == 0;
      jt          = $urandom;
      jt[1:0]     = ($urandom_range(0, 24) == 0) ? 2'($urandom) : 2'b00;
      jr_target   = jt;
      cyc();
    end
    rst_n = 1'b1;
    bus.ack = 1'b0;
    {jr, jump, branch, branch_cond, exec_done} = 5'b0;
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
